// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: PC handshake, instruction-memory port and decode-side queue head.
interface fetch_unit_if;
  logic [7:0] pc;
  logic       pc_step;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       flush;

  modport master (
    input  pc, imem_ack, imem_rdata, instr_ready, flush,
    output pc_step, imem_req, imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc, imem_ack, imem_rdata, instr_ready, flush,
    input  pc_step, imem_req, imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher feeding a 2-entry {pc, instr} queue.
module fetch_unit (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;
  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] data;
  } entry_t;

  state_e     state_q, state_d;
  logic [7:0] req_addr_q, req_addr_d;
  logic [1:0] count_q;
  logic       wr_ptr_q, rd_ptr_q;
  entry_t     mem_q [2];
  logic       push, pop;

  // Issue only with a free slot so the eventual push can never overflow.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: if (!bus.flush && count_q != 2'd2) begin
        req_addr_d = bus.pc;
        state_d    = S_WAIT;
      end
      S_WAIT: if (bus.imem_ack) begin
        state_d = S_IDLE;
        push    = !bus.flush;
      end else if (bus.flush) begin
        state_d = S_DROP;
      end
      S_DROP: if (bus.imem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = (count_q != 2'd0) && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= 8'h00;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      if (bus.flush) begin
        count_q  <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= '{pc: req_addr_q, data: bus.imem_rdata};
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  assign bus.pc_step     = push && !reset;
  assign bus.imem_req    = (state_q != S_IDLE);
  assign bus.imem_addr   = req_addr_q;
  assign bus.instr_valid = (count_q != 2'd0);
  assign bus.instr       = bus.instr_valid ? mem_q[rd_ptr_q].data : 8'h00;
  assign bus.instr_pc    = bus.instr_valid ? mem_q[rd_ptr_q].pc   : 8'h00;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, full queue, push/pop, flush, reset, wrap.
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   total, bad;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic v, input logic [7:0] d, input logic [7:0] p);
    chk({tag, "_valid"}, bus.instr_valid, v);
    chk({tag, "_instr"}, bus.instr, d);
    chk({tag, "_ipc"}, bus.instr_pc, p);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.pc = 8'h00; bus.imem_ack = 1'b0; bus.imem_rdata = 8'h00;
    bus.instr_ready = 1'b0; bus.flush = 1'b0;
    tick(); tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 8'h00);
    chk("rst_step", bus.pc_step, 0);
    head("rst", 0, 8'h00, 8'h00);

    // single fetch
    reset = 1'b0; bus.pc = 8'h10;
    tick();
    chk("f1_req", bus.imem_req, 1);
    chk("f1_addr", bus.imem_addr, 8'h10);
    chk("f1_step0", bus.pc_step, 0);
    tick();
    chk("f1_hold", bus.imem_req, 1);
    chk("f1_hold_addr", bus.imem_addr, 8'h10);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'hA5;
    #1 chk("f1_step", bus.pc_step, 1);
    head("f1_pre", 0, 8'h00, 8'h00);
    tick();
    bus.imem_ack = 1'b0;
    head("f1", 1, 8'hA5, 8'h10);
    chk("f1_step_after", bus.pc_step, 0);
    chk("f1_idle", bus.imem_req, 0);

    // second fetch fills queue
    bus.pc = 8'h11;
    tick();
    chk("f2_addr", bus.imem_addr, 8'h11);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'hB6;
    #1 chk("f2_step", bus.pc_step, 1);
    tick();
    bus.imem_ack = 1'b0;

    // full: three ack opportunities, nothing issued or pushed
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 8'hCC;
      #1;
      chk("full_req", bus.imem_req, 0);
      chk("full_step", bus.pc_step, 0);
      tick();
    end
    bus.imem_ack = 1'b0;
    head("full", 1, 8'hA5, 8'h10);

    // pop head, then push+pop at count 1
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    head("pop1", 1, 8'hB6, 8'h11);
    bus.pc = 8'h12;
    tick();
    chk("f3_addr", bus.imem_addr, 8'h12);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'hC7; bus.instr_ready = 1'b1;
    #1 chk("pp_step", bus.pc_step, 1);
    head("pp_pre", 1, 8'hB6, 8'h11);
    tick();
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    head("pp", 1, 8'hC7, 8'h12);
    bus.pc = 8'h20; bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    head("pp_drain", 0, 8'h00, 8'h00);
    chk("f4_req", bus.imem_req, 1);
    chk("f4_addr", bus.imem_addr, 8'h20);

    // flush in WAIT, late ack dropped
    bus.flush = 1'b1;
    #1 chk("fl_step", bus.pc_step, 0);
    tick();
    bus.flush = 1'b0;
    chk("drop_req", bus.imem_req, 1);
    chk("drop_addr", bus.imem_addr, 8'h20);
    tick(); tick();
    chk("drop_req2", bus.imem_req, 1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'hEE;
    #1 chk("drop_step", bus.pc_step, 0);
    tick();
    bus.imem_ack = 1'b0; bus.pc = 8'h30;
    chk("drop_idle", bus.imem_req, 0);
    head("drop", 0, 8'h00, 8'h00);
    tick();
    head("drop_late", 0, 8'h00, 8'h00);
    chk("f5_addr", bus.imem_addr, 8'h30);

    // flush coincident with ack
    bus.flush = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 8'hDD;
    #1 chk("flack_step", bus.pc_step, 0);
    tick();
    bus.flush = 1'b0; bus.imem_ack = 1'b0; bus.pc = 8'h40;
    chk("flack_idle", bus.imem_req, 0);
    head("flack", 0, 8'h00, 8'h00);
    tick();
    chk("f6_addr", bus.imem_addr, 8'h40);

    // reset mid-WAIT, with ack during reset and a stale ack afterwards
    reset = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 8'h99;
    #1 chk("rstw_step", bus.pc_step, 0);
    tick();
    reset = 1'b0; bus.imem_rdata = 8'h77; bus.pc = 8'hFF;
    chk("rstw_req", bus.imem_req, 0);
    chk("rstw_addr", bus.imem_addr, 8'h00);
    chk("stale_step", bus.pc_step, 0);
    head("rstw", 0, 8'h00, 8'h00);
    tick();
    bus.imem_ack = 1'b0;
    head("stale", 0, 8'h00, 8'h00);
    chk("wrap_addr0", bus.imem_addr, 8'hFF);

    // wrap: FF then 00
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'h11;
    #1 chk("wrap_step0", bus.pc_step, 1);
    tick();
    bus.imem_ack = 1'b0; bus.pc = 8'h00;
    tick();
    chk("wrap_addr1", bus.imem_addr, 8'h00);
    bus.imem_ack = 1'b1; bus.imem_rdata = 8'h22;
    tick();
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    head("wrap0", 1, 8'h11, 8'hFF);
    tick();
    head("wrap1", 1, 8'h22, 8'h00);
    tick();
    bus.instr_ready = 1'b0;
    head("wrap_end", 0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
